aemb_wb_ram: RTL and testbench

Synthesizable Wishbone slave memory that answers the AEMB EDK32 core's instruction (IWB) and data (DWB) bus requests. It replaces the behavioural fake memory used in simulation, so the same core can run on FPGA block RAM. It contains one shared word-addressed array with a read-only instruction port and a read/write data port with big-endian byte lanes. Each port has its own programmable wait-state sequencer that generates the acknowledge.

---
 rtl/aemb_wb_ram_pkg.sv | 21 ++
 rtl/aemb_wb_port.sv | 70 +++++++
 rtl/aemb_wb_ram.sv | 83 ++++++++
 tb/tb_aemb_wb_ram.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aemb_wb_ram_pkg.sv
// Shared definitions for the AEMB Wishbone RAM: port FSM encoding, wait
// counter width and the set of byte-lane selects that may write.
package aemb_wb_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_t;

    localparam int WCNT_W = 4;

    // Byte, aligned halfword or full word; anything else completes without writing.
    function automatic logic sel_legal(input logic [3:0] sel);
        case (sel)
            4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/aemb_wb_port.sv
// One Wishbone port sequencer: samples a request, counts NWAIT wait states,
// emits a one-cycle access pulse with the request payload, then acks.
module aemb_wb_port
    import aemb_wb_ram_pkg::*;
#(
    parameter int PW    = 14,
    parameter int NWAIT = 0
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          stb,
    input  logic [PW-1:0] pay,
    output logic          ack,
    output logic          acc,
    output logic [PW-1:0] acc_pay
);

    localparam logic [WCNT_W-1:0] WLOAD = (NWAIT == 0) ? '0 : WCNT_W'(NWAIT - 1);

    wb_state_t         state, state_nxt;
    logic [WCNT_W-1:0] cnt, cnt_nxt;
    logic [PW-1:0]     pay_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc       = 1'b0;
        acc_pay   = pay_q;
        case (state)
            ST_WAIT: begin
                if (cnt == '0) begin
                    acc       = 1'b1;
                    state_nxt = ST_ACK;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                // IDLE and ACK both accept a new request
                state_nxt = ST_IDLE;
                if (stb) begin
                    if (NWAIT == 0) begin
                        acc       = 1'b1;
                        acc_pay   = pay;
                        state_nxt = ST_ACK;
                    end else begin
                        cnt_nxt   = WLOAD;
                        state_nxt = ST_WAIT;
                    end
                end
            end
        endcase
        // an access due on a reset edge is dropped
        if (!sys_rst_i) acc = 1'b0;
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stb && state != ST_WAIT) pay_q <= pay;
        end
    end

    assign ack = (state == ST_ACK);

endmodule

// File: rtl/aemb_wb_ram.sv
// Dual-port Wishbone RAM for the AEMB core: read-only instruction port and
// big-endian byte-lane data port sharing one word array.
module aemb_wb_ram
    import aemb_wb_ram_pkg::*;
#(
    parameter int    AW        = 16,
    parameter int    IWAIT     = 0,
    parameter int    DWAIT     = 0,
    parameter string INIT_FILE = "aeMB.rom"
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          iwb_stb_i,
    input  logic [AW-1:2] iwb_adr_i,
    output logic [31:0]   iwb_dat_o,
    output logic          iwb_ack_o,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [AW-1:2] dwb_adr_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o
);

    localparam int WW    = AW - 2;
    localparam int DEPTH = 1 << WW;

    typedef struct packed {
        logic          wre;
        logic [3:0]    sel;
        logic [31:0]   dat;
        logic [WW-1:0] adr;
    } dreq_t;

    logic [31:0]   mem [DEPTH];
    logic          i_acc, d_acc, d_wr;
    logic [WW-1:0] i_adr;
    dreq_t         d_in, d_req;

    assign d_in = '{wre: dwb_wre_i, sel: dwb_sel_i, dat: dwb_dat_i, adr: dwb_adr_i};

    aemb_wb_port #(.PW(WW), .NWAIT(IWAIT)) u_iwb (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .stb       (iwb_stb_i),
        .pay       (iwb_adr_i),
        .ack       (iwb_ack_o),
        .acc       (i_acc),
        .acc_pay   (i_adr)
    );

    aemb_wb_port #(.PW($bits(dreq_t)), .NWAIT(DWAIT)) u_dwb (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .stb       (dwb_stb_i),
        .pay       (d_in),
        .ack       (dwb_ack_o),
        .acc       (d_acc),
        .acc_pay   (d_req)
    );

    assign d_wr = d_acc && d_req.wre && sel_legal(d_req.sel);

    // sel bit b enables dat[8b+7:8b]; sel[3] is the lowest byte address
    always_ff @(posedge sys_clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (d_wr && d_req.sel[b]) mem[d_req.adr][8*b +: 8] <= d_req.dat[8*b +: 8];
        end
    end

    // Read data registers see pre-write contents; dwb_dat_o only moves on reads.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            iwb_dat_o <= '0;
            dwb_dat_o <= '0;
        end else begin
            if (i_acc) iwb_dat_o <= mem[i_adr];
            if (d_acc && !d_req.wre) dwb_dat_o <= mem[d_req.adr];
        end
    end

endmodule

// File: tb/tb_aemb_wb_ram.sv
// Bench for aemb_wb_ram: two instances (no wait states / IWAIT=3,DWAIT=2)
// against a transaction-level model, plus directed literal checks.
module tb_aemb_wb_ram;

    localparam int AW    = 12;
    localparam int WW    = AW - 2;
    localparam int NI    = 2;
    localparam int DEPTH = 1 << WW;

    logic sys_clk_i = 1'b0;
    logic sys_rst_i = 1'b0;
    logic [NI-1:0]          istb = '0, dstb = '0, dwre = '0;
    logic [NI-1:0][WW-1:0]  iadr = '0, dadr = '0;
    logic [NI-1:0][3:0]     dsel = '0;
    logic [NI-1:0][31:0]    ddat = '0;
    wire  [NI-1:0]          iack, dack;
    wire  [NI-1:0][31:0]    idato, ddato;

    always #5 sys_clk_i = ~sys_clk_i;

    aemb_wb_ram #(.AW(AW), .IWAIT(0), .DWAIT(0), .INIT_FILE("")) u0 (
        .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
        .iwb_stb_i(istb[0]), .iwb_adr_i(iadr[0]), .iwb_dat_o(idato[0]), .iwb_ack_o(iack[0]),
        .dwb_stb_i(dstb[0]), .dwb_wre_i(dwre[0]), .dwb_adr_i(dadr[0]), .dwb_sel_i(dsel[0]),
        .dwb_dat_i(ddat[0]), .dwb_dat_o(ddato[0]), .dwb_ack_o(dack[0]));

    aemb_wb_ram #(.AW(AW), .IWAIT(3), .DWAIT(2), .INIT_FILE("")) u1 (
        .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
        .iwb_stb_i(istb[1]), .iwb_adr_i(iadr[1]), .iwb_dat_o(idato[1]), .iwb_ack_o(iack[1]),
        .dwb_stb_i(dstb[1]), .dwb_wre_i(dwre[1]), .dwb_adr_i(dadr[1]), .dwb_sel_i(dsel[1]),
        .dwb_dat_i(ddat[1]), .dwb_dat_o(ddato[1]), .dwb_ack_o(dack[1]));

    // Model: per instance a word array, and per port a pending request with the
    // edge number at which it is serviced; [p] 0 = IWB, 1 = DWB.
    logic [31:0]   mm    [NI][DEPTH];
    bit            mk    [NI][DEPTH];
    bit            pend  [NI][2];
    int            due   [NI][2];
    logic [WW-1:0] padr  [NI][2];
    logic          pwre  [NI];
    logic [3:0]    psel  [NI];
    logic [31:0]   pdat  [NI];
    bit            e_ack [NI][2];
    logic [31:0]   e_dat [NI][2];
    bit            e_dk  [NI][2];
    int            cyc  = 0;
    int            nchk = 0;
    int            nerr = 0;

    function automatic int wt(input int i, input int p);
        if (i == 0) return 0;
        return (p == 0) ? 3 : 2;
    endfunction

    function automatic bit legal(input logic [3:0] s);
        return s inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) e_ack[i][p] = 1'b0;
            if (!sys_rst_i) begin
                for (int p = 0; p < 2; p++) begin
                    pend[i][p]  = 1'b0;
                    e_dat[i][p] = '0;
                    e_dk[i][p]  = 1'b1;
                end
            end else begin
                if (!pend[i][0] && istb[i]) begin
                    pend[i][0] = 1'b1; due[i][0] = cyc + wt(i, 0); padr[i][0] = iadr[i];
                end
                if (!pend[i][1] && dstb[i]) begin
                    pend[i][1] = 1'b1; due[i][1] = cyc + wt(i, 1); padr[i][1] = dadr[i];
                    pwre[i] = dwre[i]; psel[i] = dsel[i]; pdat[i] = ddat[i];
                end
                // instruction read first so it sees the word before a same-edge write
                if (pend[i][0] && due[i][0] == cyc) begin
                    pend[i][0]  = 1'b0;
                    e_ack[i][0] = 1'b1;
                    e_dat[i][0] = mm[i][padr[i][0]];
                    e_dk[i][0]  = mk[i][padr[i][0]];
                end
                if (pend[i][1] && due[i][1] == cyc) begin
                    pend[i][1]  = 1'b0;
                    e_ack[i][1] = 1'b1;
                    if (!pwre[i]) begin
                        e_dat[i][1] = mm[i][padr[i][1]];
                        e_dk[i][1]  = mk[i][padr[i][1]];
                    end else if (legal(psel[i])) begin
                        for (int b = 0; b < 4; b++)
                            if (psel[i][b]) mm[i][padr[i][1]][8*b +: 8] = pdat[i][8*b +: 8];
                        if (psel[i] == 4'hF) mk[i][padr[i][1]] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d_iwb_ack", i), {31'b0, iack[i]}, {31'b0, e_ack[i][0]});
            chk($sformatf("u%0d_dwb_ack", i), {31'b0, dack[i]}, {31'b0, e_ack[i][1]});
            if (e_dk[i][0]) chk($sformatf("u%0d_iwb_dat", i), idato[i], e_dat[i][0]);
            if (e_dk[i][1]) chk($sformatf("u%0d_dwb_dat", i), ddato[i], e_dat[i][1]);
        end
    endtask

    // one clock: model consumes the edge, outputs compared at the falling edge
    task automatic tick();
        @(posedge sys_clk_i);
        model_edge();
        @(negedge sys_clk_i);
        compare();
    endtask

    task automatic dop(input int i, input logic w, input logic [WW-1:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] q, output int lat);
        dstb[i] = 1'b1; dwre[i] = w; dadr[i] = a; dsel[i] = s; ddat[i] = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!dack[i] && lat < 40);
        dstb[i] = 1'b0;
        if (!dack[i]) begin
            nchk++; nerr++;
            $display("FAIL u%0d_dwb_timeout: no ack after %0d cycles, required ack", i, lat);
        end
        q = ddato[i];
    endtask

    task automatic iop(input int i, input logic [WW-1:0] a, output logic [31:0] q, output int lat);
        istb[i] = 1'b1; iadr[i] = a;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!iack[i] && lat < 40);
        istb[i] = 1'b0;
        if (!iack[i]) begin
            nchk++; nerr++;
            $display("FAIL u%0d_iwb_timeout: no ack after %0d cycles, required ack", i, lat);
        end
        q = idato[i];
    endtask

    initial begin
        logic [31:0] q;
        int lat;

        // reset held with strobes active on every port
        istb = '1; dstb = '1; dwre = '0;
        for (int n = 0; n < 3; n++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("rst_u%0d_ack", i), {30'b0, iack[i], dack[i]}, 32'h0);
                chk($sformatf("rst_u%0d_idat", i), idato[i], 32'h0);
                chk($sformatf("rst_u%0d_ddat", i), ddato[i], 32'h0);
            end
        end
        sys_rst_i = 1'b1;
        tick();
        chk("post_rst_u0_acks", {30'b0, iack[0], dack[0]}, 32'h3);
        chk("post_rst_u1_acks", {30'b0, iack[1], dack[1]}, 32'h0);
        istb = '0; dstb = '0;
        for (int n = 0; n < 6; n++) tick();

        // give the random-traffic window known contents
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 16; a++) dop(i, 1'b1, WW'(a), 4'hF, $urandom, q, lat);

        // byte lanes on the zero-wait instance
        dop(0, 1'b1, 10'h100, 4'hF, 32'h11223344, q, lat);
        chk("dwb_w0_latency", lat, 1);
        dop(0, 1'b1, 10'h100, 4'h8, 32'hAA000000, q, lat);
        dop(0, 1'b0, 10'h100, 4'h0, 32'h0, q, lat);
        chk("lane_sel8", q, 32'hAA223344);
        dop(0, 1'b1, 10'h100, 4'h3, 32'h000055BB, q, lat);
        dop(0, 1'b0, 10'h100, 4'hF, 32'h0, q, lat);
        chk("lane_sel3", q, 32'hAA2255BB);
        dop(0, 1'b1, 10'h100, 4'h5, 32'hFFFFFFFF, q, lat);
        chk("illegal_sel_latency", lat, 1);
        dop(0, 1'b0, 10'h100, 4'hF, 32'h0, q, lat);
        chk("illegal_sel_unchanged", q, 32'hAA2255BB);

        // wait states on the second instance
        dop(1, 1'b1, 10'h040, 4'hF, 32'h0BADF00D, q, lat);
        chk("dwb_w2_latency", lat, 3);
        iop(1, 10'h040, q, lat);
        chk("iwb_w3_latency", lat, 4);
        chk("iwb_w3_data", q, 32'h0BADF00D);
        tick();
        chk("iwb_w3_ack_one_cycle", {31'b0, iack[1]}, 32'h0);

        // same-edge IWB read and DWB write of one word
        dop(0, 1'b1, 10'h020, 4'hF, 32'h12345678, q, lat);
        istb[0] = 1'b1; iadr[0] = 10'h020;
        dstb[0] = 1'b1; dwre[0] = 1'b1; dadr[0] = 10'h020; dsel[0] = 4'hF; ddat[0] = 32'hDEADBEEF;
        tick();
        istb[0] = 1'b0; dstb[0] = 1'b0;
        chk("collide_acks", {30'b0, iack[0], dack[0]}, 32'h3);
        chk("collide_iwb_old", idato[0], 32'h12345678);
        dop(0, 1'b0, 10'h020, 4'hF, 32'h0, q, lat);
        chk("collide_dwb_new", q, 32'hDEADBEEF);

        // reset lands while a DWAIT=2 write is still waiting
        dop(1, 1'b1, 10'h030, 4'hF, 32'h11110000, q, lat);
        dstb[1] = 1'b1; dwre[1] = 1'b1; dadr[1] = 10'h030; dsel[1] = 4'hF; ddat[1] = 32'hCAFEF00D;
        tick();
        dstb[1] = 1'b0;
        sys_rst_i = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tick();
            chk("midrst_no_ack", {31'b0, dack[1]}, 32'h0);
        end
        sys_rst_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("midrst_no_late_ack", {31'b0, dack[1]}, 32'h0);
        end
        dop(1, 1'b0, 10'h030, 4'hF, 32'h0, q, lat);
        chk("midrst_word_kept", q, 32'h11110000);

        // random traffic on both instances, occasional reset
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NI; i++) begin
                istb[i] = 1'($urandom_range(0, 1));
                iadr[i] = WW'($urandom_range(0, 15));
                dstb[i] = 1'($urandom_range(0, 1));
                dwre[i] = 1'($urandom_range(0, 1));
                dadr[i] = WW'($urandom_range(0, 15));
                dsel[i] = 4'($urandom);
                ddat[i] = $urandom;
            end
            sys_rst_i = ($urandom_range(0, 63) != 0);
            tick();
        end
        istb = '0; dstb = '0; sys_rst_i = 1'b1;
        for (int n = 0; n < 6; n++) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
